// File: rtl/serial_cmp_pkg_amisha.sv
// Shared types for the bit-serial comparator: FSM state encoding.
package serial_cmp_pkg_amisha;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/eq1_cell_amisha.sv
// Gate-level 1-bit equality cell: e = x XNOR y built from not/and/or.
module eq1_cell_amisha (
  input  wire x,
  input  wire y,
  output wire e
);

  wire nx;
  wire ny;
  wire both1;
  wire both0;

  not u_nx (nx, x);
  not u_ny (ny, y);
  and u_both1 (both1, x, y);
  and u_both0 (both0, nx, ny);
  or  u_eq (e, both1, both0);

endmodule

// File: rtl/serial_cmp_amisha.sv
// Bit-serial MSB-first unsigned comparator with early exit on the first differing bit.
//   state   | meaning
//   S_IDLE  | ready for a new operand pair, results held
//   S_SHIFT | one bit compare per clock on the shift-register MSBs
//   S_DONE  | one-cycle done pulse, results valid
module serial_cmp_amisha
  import serial_cmp_pkg_amisha::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             start_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             ready_amisha,
  output logic             done_amisha,
  output logic             eq_amisha,
  output logic             gt_amisha,
  output logic             lt_amisha,
  output logic [CNT_W-1:0] cycles_amisha
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eq_d, gt_d, lt_d;
  logic [CNT_W-1:0] cycles_d;
  wire              bit_eq;

  eq1_cell_amisha u_eq1 (
    .x (sa_q[WIDTH-1]),
    .y (sb_q[WIDTH-1]),
    .e (bit_eq)
  );

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q       <= S_IDLE;
      sa_q          <= '0;
      sb_q          <= '0;
      cnt_q         <= '0;
      eq_amisha     <= 1'b0;
      gt_amisha     <= 1'b0;
      lt_amisha     <= 1'b0;
      cycles_amisha <= '0;
    end else begin
      state_q       <= state_d;
      sa_q          <= sa_d;
      sb_q          <= sb_d;
      cnt_q         <= cnt_d;
      eq_amisha     <= eq_d;
      gt_amisha     <= gt_d;
      lt_amisha     <= lt_d;
      cycles_amisha <= cycles_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    cnt_d        = cnt_q;
    eq_d         = eq_amisha;
    gt_d         = gt_amisha;
    lt_d         = lt_amisha;
    cycles_d     = cycles_amisha;
    ready_amisha = 1'b0;
    done_amisha  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_amisha = 1'b1;
        if (start_amisha) begin
          sa_d    = a_amisha;
          sb_d    = b_amisha;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!bit_eq) begin
          // first differing bit decides: A has the 1 means A is larger
          eq_d     = 1'b0;
          gt_d     = sa_q[WIDTH-1];
          lt_d     = ~sa_q[WIDTH-1];
          cycles_d = cnt_q + CNT_W'(1);
          state_d  = S_DONE;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          eq_d     = 1'b1;
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          cycles_d = CNT_W'(WIDTH);
          state_d  = S_DONE;
        end else begin
          sa_d = sa_q << 1;
          sb_d = sb_q << 1;
        end
      end
      S_DONE: begin
        done_amisha = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_cmp_amisha.sv
// Directed bench for serial_cmp_amisha: WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_cmp_amisha;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic       ready, done, eq, gt, lt;
  logic [3:0] cycles;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       ready1, done1, eq1, gt1, lt1;
  logic [0:0] cycles1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_cmp_amisha #(.WIDTH(8)) dut (
    .clk_amisha    (clk),
    .rst_n_amisha  (rst_n),
    .start_amisha  (start),
    .a_amisha      (a_i),
    .b_amisha      (b_i),
    .ready_amisha  (ready),
    .done_amisha   (done),
    .eq_amisha     (eq),
    .gt_amisha     (gt),
    .lt_amisha     (lt),
    .cycles_amisha (cycles)
  );

  serial_cmp_amisha #(.WIDTH(1)) dut_w1 (
    .clk_amisha    (clk),
    .rst_n_amisha  (rst_n),
    .start_amisha  (start1),
    .a_amisha      (a1),
    .b_amisha      (b1),
    .ready_amisha  (ready1),
    .done_amisha   (done1),
    .eq_amisha     (eq1),
    .gt_amisha     (gt1),
    .lt_amisha     (lt1),
    .cycles_amisha (cycles1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // k = expected number of bit compares = edges from acceptance until done is seen
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic e_eq, input logic e_gt, input logic e_lt, input int k);
    int n;
    @(negedge clk);
    chk({tag, "_ready_pre"}, 32'(ready), 1);
    a_i = a; b_i = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = ~a; b_i = 8'h5A;
    chk({tag, "_ready_busy"}, 32'(ready), 0);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(k));
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_eq"}, 32'(eq), 32'(e_eq));
    chk({tag, "_gt"}, 32'(gt), 32'(e_gt));
    chk({tag, "_lt"}, 32'(lt), 32'(e_lt));
    chk({tag, "_cycles"}, 32'(cycles), 32'(k));
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 32'(done), 0);
    chk({tag, "_ready_back"}, 32'(ready), 1);
    chk({tag, "_eq_hold"}, 32'(eq), 32'(e_eq));
  endtask

  task automatic do_op1(input string tag, input logic a, input logic b,
                        input logic e_eq, input logic e_gt, input logic e_lt);
    int n;
    @(negedge clk);
    a1 = a; b1 = b; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 1);
    chk({tag, "_eq"}, 32'(eq1), 32'(e_eq));
    chk({tag, "_gt"}, 32'(gt1), 32'(e_gt));
    chk({tag, "_lt"}, 32'(lt1), 32'(e_lt));
    chk({tag, "_cycles"}, 32'(cycles1), 1);
    @(posedge clk); #1;
    chk({tag, "_ready_back"}, 32'(ready1), 1);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_flags", {29'd0, eq, gt, lt}, 0);
    chk("rst_cycles", 32'(cycles), 0);
    @(negedge clk); rst_n = 1'b1;

    do_op("t1_eq", 8'hA5, 8'hA5, 1, 0, 0, 8);
    do_op("t2_msb", 8'h80, 8'h00, 0, 1, 0, 1);
    do_op("t3_lsb", 8'h12, 8'h13, 0, 0, 1, 8);
    do_op("t3_b6", 8'h40, 8'h20, 0, 1, 0, 2);

    // start while busy is ignored; held start is taken in the first IDLE cycle
    @(negedge clk);
    a_i = 8'h0F; b_i = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a_i = 8'h00; b_i = 8'hFF;
    n = 3;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_latency", 32'(n), 8);
    chk("t4_eq", {29'd0, eq, gt, lt}, 32'b100);
    chk("t4_cycles", 32'(cycles), 8);
    @(posedge clk); #1;
    chk("t4_idle_ready", 32'(ready), 1);
    chk("t4_idle_done", 32'(done), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_accepted", 32'(ready), 0);
    @(posedge clk); #1;
    chk("t4b_done", 32'(done), 1);
    chk("t4b_flags", {29'd0, eq, gt, lt}, 32'b001);
    chk("t4b_cycles", 32'(cycles), 1);
    @(posedge clk); #1;

    // asynchronous reset mid-compare
    @(negedge clk);
    a_i = 8'hA5; b_i = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_ready", 32'(ready), 1);
    chk("t5_done", 32'(done), 0);
    chk("t5_flags", {29'd0, eq, gt, lt}, 0);
    chk("t5_cycles", 32'(cycles), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_pulse", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    do_op("t5_after", 8'h01, 8'h02, 0, 0, 1, 7);

    do_op1("t6_gt", 1'b1, 1'b0, 0, 1, 0);
    do_op1("t6_eq", 1'b1, 1'b1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
